// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit carry-lookahead slice, LS nibble first.
// Optional subtract support is compiled in with `define CLA_SEQ_SUB_EN.
module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSL = WIDTH / 4;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic [IW-1:0]    idx_q;
`ifdef CLA_SEQ_SUB_EN
    logic             sub_q;
`endif

    logic [3:0] a_nib, b_nib, g, p, nib_sum_d;
    logic [4:0] c;
    logic       carry_d;

    // One 4-bit lookahead slice: every carry is a flat function of g/p and the slice carry-in.
    always_comb begin
        a_nib = a_q[4*idx_q +: 4];
        b_nib = b_q[4*idx_q +: 4];
`ifdef CLA_SEQ_SUB_EN
        b_nib = b_nib ^ {4{sub_q}};
`endif
        g    = a_nib & b_nib;
        p    = a_nib ^ b_nib;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_sum_d = p ^ c[3:0];
        carry_d   = c[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
                        sub_q   <= sub;
                        // Two's-complement subtract: the +1 enters as the initial carry.
                        carry_q <= sub ? 1'b1 : cin;
`else
                        carry_q <= cin;
`endif
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[4*idx_q +: 4] <= nib_sum_d;
                    carry_q             <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
